// File: rtl/multicycle_main_fsm_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes,
// datapath mux selects and the bundle of control lines the main FSM drives.
package multicycle_main_fsm_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWRITE = 4'd4,
      S_MEMWB    = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_JALR     = 4'd11,
      S_LUI      = 4'd12
   } state_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RESULT_ALUOUT    = 2'b00;
   localparam logic [1:0] RESULT_DATA      = 2'b01;
   localparam logic [1:0] RESULT_ALURESULT = 2'b10;

   typedef struct packed {
      logic       pcUpdate;
      logic       branch;
      logic       irWrite;
      logic       regWrite;
      logic       memWrite;
      logic       memReq;
      logic       adrSrc;
      logic [1:0] resultSrc;
      logic [1:0] aluSrcA;
      logic [1:0] aluSrcB;
      logic [1:0] aluOp;
   } ctrl_t;

endpackage

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle RV32I core: sequences each instruction from
// its opcode and decodes every datapath enable and mux select from the state.
module multicycle_main_fsm
   import multicycle_main_fsm_pkg::*;
#(
   parameter bit MEM_HANDSHAKE = 1'b1,
   parameter int STATE_W       = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [6:0]         op,
   input  logic               mem_ready,
   output logic               PCUpdate,
   output logic               Branch,
   output logic               IRWrite,
   output logic               RegWrite,
   output logic               MemWrite,
   output logic               mem_req,
   output logic               AdrSrc,
   output logic [1:0]         ResultSrc,
   output logic [1:0]         ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         ALUOp,
   output logic               illegal_op,
   output logic [STATE_W-1:0] state_o
);

   state_e state_q;
   state_e state_d;
   logic   memReady;
   logic   opKnown;
   ctrl_t  ctrl;

   assign memReady = MEM_HANDSHAKE ? mem_ready : 1'b1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      opKnown = 1'b1;
      case (state_q)
         S_FETCH:    if (memReady) state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECUTER;
               OP_ITYPE:          state_d = S_EXECUTEI;
               OP_BRANCH:         state_d = S_BRANCH;
               OP_JAL:            state_d = S_JAL;
               OP_JALR:           state_d = S_JALR;
               OP_LUI:            state_d = S_LUI;
               OP_AUIPC:          state_d = S_ALUWB;
               default: begin
                  state_d = S_FETCH;
                  opKnown = 1'b0;
               end
            endcase
         end
         S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  if (memReady) state_d = S_MEMWB;
         S_MEMWRITE: if (memReady) state_d = S_FETCH;
         S_EXECUTER, S_EXECUTEI, S_JAL, S_LUI: state_d = S_ALUWB;
         S_JALR:     state_d = S_JAL;
         default:    state_d = S_FETCH;
      endcase
   end

   // JAL reuses ALUOut (rs1+imm from JALR, or OldPC+imm from DECODE) as the new PC
   // while the ALU forms the link address OldPC+4 for ALUWB to write back.
   always_comb begin
      ctrl       = '0;
      illegal_op = 1'b0;
      case (state_q)
         S_FETCH: begin
            ctrl.memReq    = 1'b1;
            ctrl.aluSrcA   = SRCA_PC;
            ctrl.aluSrcB   = SRCB_FOUR;
            ctrl.aluOp     = ALUOP_ADD;
            ctrl.resultSrc = RESULT_ALURESULT;
            ctrl.irWrite   = memReady;
            ctrl.pcUpdate  = memReady;
         end
         S_DECODE: begin
            ctrl.aluSrcA = SRCA_OLDPC;
            ctrl.aluSrcB = SRCB_IMM;
            ctrl.aluOp   = ALUOP_ADD;
            illegal_op   = !opKnown;
         end
         S_MEMADR, S_JALR: begin
            ctrl.aluSrcA = SRCA_RS1;
            ctrl.aluSrcB = SRCB_IMM;
            ctrl.aluOp   = ALUOP_ADD;
         end
         S_MEMREAD: begin
            ctrl.memReq    = 1'b1;
            ctrl.adrSrc    = 1'b1;
            ctrl.resultSrc = RESULT_ALUOUT;
         end
         S_MEMWRITE: begin
            ctrl.memReq    = 1'b1;
            ctrl.memWrite  = 1'b1;
            ctrl.adrSrc    = 1'b1;
            ctrl.resultSrc = RESULT_ALUOUT;
         end
         S_MEMWB: begin
            ctrl.resultSrc = RESULT_DATA;
            ctrl.regWrite  = 1'b1;
         end
         S_EXECUTER: begin
            ctrl.aluSrcA = SRCA_RS1;
            ctrl.aluSrcB = SRCB_RS2;
            ctrl.aluOp   = ALUOP_FUNCT;
         end
         S_EXECUTEI: begin
            ctrl.aluSrcA = SRCA_RS1;
            ctrl.aluSrcB = SRCB_IMM;
            ctrl.aluOp   = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            ctrl.resultSrc = RESULT_ALUOUT;
            ctrl.regWrite  = 1'b1;
         end
         S_BRANCH: begin
            ctrl.aluSrcA   = SRCA_RS1;
            ctrl.aluSrcB   = SRCB_RS2;
            ctrl.aluOp     = ALUOP_SUB;
            ctrl.resultSrc = RESULT_ALUOUT;
            ctrl.branch    = 1'b1;
         end
         S_JAL: begin
            ctrl.aluSrcA   = SRCA_OLDPC;
            ctrl.aluSrcB   = SRCB_FOUR;
            ctrl.aluOp     = ALUOP_ADD;
            ctrl.resultSrc = RESULT_ALUOUT;
            ctrl.pcUpdate  = 1'b1;
         end
         S_LUI: begin
            ctrl.aluSrcA = SRCA_ZERO;
            ctrl.aluSrcB = SRCB_IMM;
            ctrl.aluOp   = ALUOP_ADD;
         end
         default: ;
      endcase
   end

   // Enables are gated by reset_n directly so nothing can fire while reset is held.
   assign PCUpdate  = reset_n & ctrl.pcUpdate;
   assign Branch    = reset_n & ctrl.branch;
   assign IRWrite   = reset_n & ctrl.irWrite;
   assign RegWrite  = reset_n & ctrl.regWrite;
   assign MemWrite  = reset_n & ctrl.memWrite;
   assign mem_req   = reset_n & ctrl.memReq;
   assign AdrSrc    = ctrl.adrSrc;
   assign ResultSrc = ctrl.resultSrc;
   assign ALUSrcA   = ctrl.aluSrcA;
   assign ALUSrcB   = ctrl.aluSrcB;
   assign ALUOp     = ctrl.aluOp;
   assign state_o   = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Testbench for multicycle_main_fsm: an instruction-level reference model expands
// each opcode into its phase sequence and predicts every output cycle by cycle.
module tb_multicycle_main_fsm;
   import multicycle_main_fsm_pkg::*;

   typedef enum int {
      PH_FETCH, PH_DECODE, PH_MEMADR, PH_MEMREAD, PH_MEMWRITE, PH_MEMWB,
      PH_EXECR, PH_EXECI, PH_ALUWB, PH_BRANCH, PH_JAL, PH_JALR, PH_LUI, PH_NONE
   } phase_e;
   typedef phase_e phaseQ_t[$];

   typedef struct packed {
      logic [3:0] state;
      logic       pcUpdate;
      logic       branch;
      logic       irWrite;
      logic       regWrite;
      logic       memWrite;
      logic       memReq;
      logic       adrSrc;
      logic [1:0] resultSrc;
      logic [1:0] srcA;
      logic [1:0] srcB;
      logic [1:0] aluOp;
      logic       illegal;
   } out_t;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [6:0] op;
   logic       mem_ready;
   logic       PCUpdate, Branch, IRWrite, RegWrite, MemWrite, mem_req, AdrSrc, illegal_op;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
   logic [3:0] state_o;

   logic       resetNh;
   logic [6:0] opNh;
   logic       memReadyNh;
   logic       pcUpdateNh, branchNh, irWriteNh, regWriteNh, memWriteNh, memReqNh, adrSrcNh, illegalNh;
   logic [1:0] resultSrcNh, srcANh, srcBNh, aluOpNh;
   logic [3:0] stateNh;

   int   checks   = 0;
   int   failures = 0;
   out_t traceLog[$];

   always #5 clk = ~clk;

   multicycle_main_fsm #(.MEM_HANDSHAKE(1'b1), .STATE_W(4)) dut (
      .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
      .PCUpdate(PCUpdate), .Branch(Branch), .IRWrite(IRWrite), .RegWrite(RegWrite),
      .MemWrite(MemWrite), .mem_req(mem_req), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .illegal_op(illegal_op),
      .state_o(state_o)
   );

   multicycle_main_fsm #(.MEM_HANDSHAKE(1'b0), .STATE_W(4)) dutNh (
      .clk(clk), .reset_n(resetNh), .op(opNh), .mem_ready(memReadyNh),
      .PCUpdate(pcUpdateNh), .Branch(branchNh), .IRWrite(irWriteNh), .RegWrite(regWriteNh),
      .MemWrite(memWriteNh), .mem_req(memReqNh), .AdrSrc(adrSrcNh), .ResultSrc(resultSrcNh),
      .ALUSrcA(srcANh), .ALUSrcB(srcBNh), .ALUOp(aluOpNh), .illegal_op(illegalNh),
      .state_o(stateNh)
   );

   // Phases each instruction class walks through after FETCH.
   function automatic phaseQ_t planFor(input logic [6:0] opc);
      phaseQ_t p;
      p.push_back(PH_DECODE);
      case (opc)
         7'b0000011: begin p.push_back(PH_MEMADR); p.push_back(PH_MEMREAD); p.push_back(PH_MEMWB); end
         7'b0100011: begin p.push_back(PH_MEMADR); p.push_back(PH_MEMWRITE); end
         7'b0110011: begin p.push_back(PH_EXECR); p.push_back(PH_ALUWB); end
         7'b0010011: begin p.push_back(PH_EXECI); p.push_back(PH_ALUWB); end
         7'b1100011: p.push_back(PH_BRANCH);
         7'b1101111: begin p.push_back(PH_JAL); p.push_back(PH_ALUWB); end
         7'b1100111: begin p.push_back(PH_JALR); p.push_back(PH_JAL); p.push_back(PH_ALUWB); end
         7'b0110111: begin p.push_back(PH_LUI); p.push_back(PH_ALUWB); end
         7'b0010111: p.push_back(PH_ALUWB);
         default: ;
      endcase
      return p;
   endfunction

   function automatic out_t expectFor(input phase_e ph, input logic rdy, input logic [6:0] opc);
      out_t e = '0;
      phaseQ_t p = planFor(opc);
      case (ph)
         PH_FETCH:    begin e.state = S_FETCH; e.memReq = 1'b1; e.srcB = 2'b10; e.resultSrc = 2'b10;
                            e.irWrite = rdy; e.pcUpdate = rdy; end
         PH_DECODE:   begin e.state = S_DECODE; e.srcA = 2'b01; e.srcB = 2'b01; e.illegal = (p.size() == 1); end
         PH_MEMADR:   begin e.state = S_MEMADR; e.srcA = 2'b10; e.srcB = 2'b01; end
         PH_MEMREAD:  begin e.state = S_MEMREAD; e.memReq = 1'b1; e.adrSrc = 1'b1; end
         PH_MEMWRITE: begin e.state = S_MEMWRITE; e.memReq = 1'b1; e.memWrite = 1'b1; e.adrSrc = 1'b1; end
         PH_MEMWB:    begin e.state = S_MEMWB; e.resultSrc = 2'b01; e.regWrite = 1'b1; end
         PH_EXECR:    begin e.state = S_EXECUTER; e.srcA = 2'b10; e.aluOp = 2'b10; end
         PH_EXECI:    begin e.state = S_EXECUTEI; e.srcA = 2'b10; e.srcB = 2'b01; e.aluOp = 2'b10; end
         PH_ALUWB:    begin e.state = S_ALUWB; e.regWrite = 1'b1; end
         PH_BRANCH:   begin e.state = S_BRANCH; e.srcA = 2'b10; e.aluOp = 2'b01; e.branch = 1'b1; end
         PH_JALR:     begin e.state = S_JALR; e.srcA = 2'b10; e.srcB = 2'b01; end
         PH_JAL:      begin e.state = S_JAL; e.srcA = 2'b01; e.srcB = 2'b10; e.pcUpdate = 1'b1; end
         PH_LUI:      begin e.state = S_LUI; e.srcA = 2'b11; e.srcB = 2'b01; end
         default: ;
      endcase
      return e;
   endfunction

   function automatic out_t sampleMain();
      out_t o;
      o.state = state_o; o.pcUpdate = PCUpdate; o.branch = Branch; o.irWrite = IRWrite;
      o.regWrite = RegWrite; o.memWrite = MemWrite; o.memReq = mem_req; o.adrSrc = AdrSrc;
      o.resultSrc = ResultSrc; o.srcA = ALUSrcA; o.srcB = ALUSrcB; o.aluOp = ALUOp;
      o.illegal = illegal_op;
      return o;
   endfunction

   // Entered at a negedge; runs one instruction, checking every cycle, and returns
   // at a negedge (or just after the abort phase has been checked).
   task automatic runInstr(input logic [6:0] opc, input int fetchWaits, input int memWaits,
                           input phase_e abortAt, output int cycles);
      phaseQ_t plan;
      int      idx;
      int      waitLeft;
      phase_e  ph;
      bit      isMem;
      logic    rdy;
      out_t    obs;
      out_t    exp;
      plan = planFor(opc);
      plan.push_front(PH_FETCH);
      idx = 0;
      waitLeft = fetchWaits;
      cycles = 0;
      traceLog.delete();
      while (idx < plan.size()) begin
         ph    = plan[idx];
         isMem = (ph == PH_FETCH) || (ph == PH_MEMREAD) || (ph == PH_MEMWRITE);
         rdy   = isMem ? (waitLeft == 0) : 1'($urandom);
         op = opc;
         mem_ready = rdy;
         #1;
         obs = sampleMain();
         exp = expectFor(ph, rdy, opc);
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL cycle op=%b phase=%0d cyc=%0d got=%h want=%h", opc, ph, cycles, obs, exp);
         end
         traceLog.push_back(obs);
         cycles++;
         if (ph == abortAt) return;
         if (isMem && !rdy) begin
            waitLeft--;
         end else begin
            idx++;
            waitLeft = memWaits;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      out_t obs;
      out_t exp;
      reset_n = 1'b0; op = 7'b0; mem_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      obs = sampleMain();
      exp = '0; exp.state = S_FETCH; exp.srcB = 2'b10; exp.resultSrc = 2'b10;
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL reset_state got=%h want=%h", obs, exp);
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset_mid_memwrite();
      int   cycles;
      out_t obs;
      out_t exp;
      int   regCount;
      runInstr(7'b0100011, 0, 5, PH_MEMWRITE, cycles);
      reset_n = 1'b0;
      #1;
      exp = '0; exp.state = S_FETCH; exp.srcB = 2'b10; exp.resultSrc = 2'b10;
      for (int i = 0; i < 3; i++) begin
         obs = sampleMain();
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL reset_mid_write i=%0d got=%h want=%h", i, obs, exp);
         end
         @(negedge clk);
         mem_ready = 1'b1;
         #1;
      end
      @(negedge clk);
      reset_n = 1'b1;
      runInstr(7'b0110011, 0, 0, PH_NONE, cycles);
      checks++;
      if (cycles !== 4 || traceLog[2].state !== S_EXECUTER || traceLog[3].state !== S_ALUWB) begin
         failures++;
         $display("[TB] FAIL rtype_after_reset cycles=%0d st2=%0d st3=%0d want 4/%0d/%0d",
                  cycles, traceLog[2].state, traceLog[3].state, S_EXECUTER, S_ALUWB);
      end
      checks++;
      if (traceLog[2].aluOp !== 2'b10) begin
         failures++;
         $display("[TB] FAIL rtype_aluop got=%b want=10", traceLog[2].aluOp);
      end
      regCount = 0;
      foreach (traceLog[i]) if (traceLog[i].regWrite) regCount++;
      checks++;
      if (regCount !== 1 || traceLog[3].regWrite !== 1'b1) begin
         failures++;
         $display("[TB] FAIL rtype_regwrite count=%0d last=%b want 1/1", regCount, traceLog[3].regWrite);
      end
   endtask

   task automatic test_lw_waits();
      int cycles;
      int irCount;
      int pcCount;
      runInstr(7'b0000011, 2, 3, PH_NONE, cycles);
      irCount = 0; pcCount = 0;
      foreach (traceLog[i]) begin
         if (traceLog[i].irWrite) irCount++;
         if (traceLog[i].pcUpdate) pcCount++;
      end
      checks++;
      if (cycles !== 10) begin
         failures++;
         $display("[TB] FAIL lw_cycles got=%0d want=10", cycles);
      end
      checks++;
      if (irCount !== 1 || pcCount !== 1) begin
         failures++;
         $display("[TB] FAIL lw_fetch_pulses ir=%0d pc=%0d want 1/1", irCount, pcCount);
      end
      checks++;
      if (traceLog[cycles-1].regWrite !== 1'b1 || traceLog[cycles-1].resultSrc !== 2'b01) begin
         failures++;
         $display("[TB] FAIL lw_writeback reg=%b res=%b want 1/01",
                  traceLog[cycles-1].regWrite, traceLog[cycles-1].resultSrc);
      end
   endtask

   task automatic test_sw();
      int cycles;
      int mwCount;
      int regCount;
      bit adrOk;
      runInstr(7'b0100011, 0, 0, PH_NONE, cycles);
      mwCount = 0; regCount = 0; adrOk = 1'b1;
      foreach (traceLog[i]) begin
         if (traceLog[i].memWrite) begin
            mwCount++;
            if (traceLog[i].adrSrc !== 1'b1) adrOk = 1'b0;
         end
         if (traceLog[i].regWrite) regCount++;
      end
      checks++;
      if (cycles !== 4 || mwCount !== 1 || !adrOk || regCount !== 0) begin
         failures++;
         $display("[TB] FAIL sw cycles=%0d memWrite=%0d adrOk=%0d regWrite=%0d want 4/1/1/0",
                  cycles, mwCount, adrOk, regCount);
      end
   endtask

   task automatic test_beq();
      int   cycles;
      out_t b;
      runInstr(7'b1100011, 0, 0, PH_NONE, cycles);
      b = traceLog[2];
      checks++;
      if (cycles !== 3 || b.state !== S_BRANCH || b.aluOp !== 2'b01 || b.srcA !== 2'b10 ||
          b.srcB !== 2'b00 || b.branch !== 1'b1 || b.pcUpdate !== 1'b0) begin
         failures++;
         $display("[TB] FAIL beq cycles=%0d got=%h want state=%0d aluop=01 srca=10 srcb=00 br=1 pc=0",
                  cycles, b, S_BRANCH);
      end
   endtask

   task automatic test_jalr();
      int cycles;
      int pcCount;
      runInstr(7'b1100111, 0, 0, PH_NONE, cycles);
      checks++;
      if (traceLog[2].state !== S_JALR || traceLog[3].state !== S_JAL || traceLog[4].state !== S_ALUWB) begin
         failures++;
         $display("[TB] FAIL jalr_states got=%0d,%0d,%0d want %0d,%0d,%0d", traceLog[2].state,
                  traceLog[3].state, traceLog[4].state, S_JALR, S_JAL, S_ALUWB);
      end
      pcCount = 0;
      foreach (traceLog[i]) if (traceLog[i].pcUpdate) pcCount++;
      checks++;
      if (pcCount !== 2 || traceLog[0].pcUpdate !== 1'b1 || traceLog[3].pcUpdate !== 1'b1 ||
          traceLog[3].srcB !== 2'b10) begin
         failures++;
         $display("[TB] FAIL jalr_pcupdate count=%0d fetch=%b jal=%b jalSrcB=%b want 2/1/1/10",
                  pcCount, traceLog[0].pcUpdate, traceLog[3].pcUpdate, traceLog[3].srcB);
      end
   endtask

   task automatic test_illegal();
      int cycles;
      int illCount;
      int wrCount;
      runInstr(7'b1111111, 0, 0, PH_NONE, cycles);
      #1;
      illCount = 0; wrCount = 0;
      foreach (traceLog[i]) begin
         if (traceLog[i].illegal) illCount++;
         if (traceLog[i].regWrite || traceLog[i].memWrite) wrCount++;
      end
      checks++;
      if (illCount !== 1 || traceLog[1].illegal !== 1'b1 || wrCount !== 0 || state_o !== S_FETCH) begin
         failures++;
         $display("[TB] FAIL illegal count=%0d atDecode=%b writes=%0d next=%0d want 1/1/0/%0d",
                  illCount, traceLog[1].illegal, wrCount, state_o, S_FETCH);
      end
      @(negedge clk);
   endtask

   task automatic test_no_handshake();
      logic [3:0] wantState;
      resetNh = 1'b0; opNh = 7'b1111111; memReadyNh = 1'b0;
      @(negedge clk);
      resetNh = 1'b1;
      for (int k = 0; k < 6; k++) begin
         #1;
         wantState = (k % 2 == 0) ? S_FETCH : S_DECODE;
         checks++;
         if (stateNh !== wantState || irWriteNh !== (k % 2 == 0) || illegalNh !== (k % 2 == 1) ||
             regWriteNh !== 1'b0 || memWriteNh !== 1'b0) begin
            failures++;
            $display("[TB] FAIL no_handshake k=%0d state=%0d ir=%b ill=%b reg=%b mw=%b want state=%0d",
                     k, stateNh, irWriteNh, illegalNh, regWriteNh, memWriteNh, wantState);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_random();
      logic [6:0] ops [10];
      logic [6:0] opc;
      int         cycles;
      phaseQ_t    p;
      ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
              7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0000000};
      for (int n = 0; n < 60; n++) begin
         opc = ops[$urandom_range(9)];
         if (opc == 7'b0000000) begin
            opc = 7'($urandom);
            p = planFor(opc);
            if (p.size() != 1) opc = 7'b1111111;
         end
         runInstr(opc, $urandom_range(3), $urandom_range(3), PH_NONE, cycles);
      end
   endtask

   initial begin
      resetNh = 1'b0; opNh = 7'b0; memReadyNh = 1'b0;
      test_reset();
      test_reset_mid_memwrite();
      test_lw_waits();
      test_sw();
      test_beq();
      test_jalr();
      test_illegal();
      test_no_handshake();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #300000;
      $display("[TB] FAIL timeout reached without completing the test sequence");
      $fatal(1, "[TB] timeout");
   end

endmodule
